adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one 5-bit ripple adder between NREQ requesters in the snake core: head-X step, head-Y step and score increment.
- Each transaction is a registered round-robin req/grant handshake. Operands are latched at grant, and a registered mod-32 sum is returned with a one-cycle DONE pulse.
- Instantiates the team's existing 5-bit adder internally. No other instance drives that adder.

Parameters:
- NREQ, 3, number of requesters (2..8)
- PTR_W, 3, width of the round-robin pointer; must be at least clog2(NREQ)

Ports:
- CLK  in  1  single system clock, rising edge
- RESET_N  in  1  reset, synchronous, active-low
- REQ  in  NREQ  per-requester request level, held until DONE is seen
- OPA  in  5*NREQ  packed operand A; requester i uses bits [5i+4:5i]
- OPB  in  5*NREQ  packed operand B, same packing as OPA
- GNT  out  NREQ  one-hot grant, high from the ADD state through the RESP state
- DONE  out  1  one-cycle pulse; RESULT is valid for the granted requester
- RESULT  out  5  registered (OPA+OPB) mod 32
- BUSY  out  1  high in the ADD and RESP states

Behaviour:
- Reset: RESET_N low at a rising edge forces state=IDLE, GNT=0, DONE=0, RESULT=0, BUSY=0, operand latches=0 and pointer=NREQ-1 (so req0 has top priority first).
- Reset mid-transaction: the transaction is aborted. No DONE is issued, and the requester must re-request.
- FSM states: IDLE, ADD, RESP. Exactly one transaction is in flight at a time.
- IDLE: if REQ is nonzero, the winner is the first asserted index scanning from pointer+1 upward, wrapping mod NREQ.
  - Latch OPA/OPB of the winner, set GNT to the winner's one-hot, load pointer with the winner, go to ADD.
  - If REQ is zero, stay in IDLE.
- ADD, one cycle: the latched operands drive the adder with Ci=0. The sum is registered into RESULT at the end of the cycle. Go to RESP.
- RESP, one cycle: DONE=1, GNT held, RESULT stable. Go to IDLE unconditionally.
- Latency: REQ sampled in IDLE cycle N; GNT is visible in cycle N+1; DONE and RESULT are visible in cycle N+2. Minimum issue interval per transaction is 3 cycles.
- Requester rule: REQ is deasserted at the edge following the DONE cycle. A REQ still high in the following IDLE cycle is a new request.
- Operand changes after grant are ignored, because the latched values are used.
- If REQ[winner] drops during ADD or RESP, the transaction still completes and DONE still pulses.
- Arithmetic: 5-bit sum with the carry discarded, e.g. 31+1=0 and 20+15=3. This wrap-around is the intended grid wrap.
- RESULT holds its last value outside RESP. GNT=0 and DONE=0 in IDLE.
- Fairness: with all requesters held high, grants rotate 0,1,...,NREQ-1,0,... No requester waits more than NREQ transactions.

Optional Feature:
- Macro: ADDER_CARRY_FLAG_EN.
- Defined: adds output port OVF, 1 bit, registered alongside RESULT. OVF=1 when OPA+OPB>=32, computed as a 6-bit sum of the latched operands; the edge-crossing event feeds snake wrap logic. OVF resets to 0 and holds its value outside RESP.
- Undefined: no OVF port and no extra logic; RESULT is unchanged.

Test Plan:
- Reset then single request: REQ=001, OPA0=7, OPB0=9 → GNT=001 one cycle later, then DONE=1 with RESULT=16 two cycles after REQ; BUSY=0 afterwards.
- Wrap: requester 1 with OPA=31, OPB=1 → RESULT=0; with ADDER_CARRY_FLAG_EN, OVF=1. A second request 20+15 → RESULT=3, OVF=1. A third request 10+5 → RESULT=15, OVF=0.
- Round robin: REQ=111 held through 6 transactions → GNT order 0,1,2,0,1,2, with exactly one DONE per 3 cycles.
- Operand hold: after grant of OPA0=4, OPB0=4, change OPA0 to 30 during ADD → RESULT=8.
- Reset mid-operation: RESET_N low for 1 cycle during ADD → GNT=0, DONE never pulses, RESULT=0. Next REQ=100 is granted to requester 2, and pointer rotation restarts from req0 priority.
- Early drop: requester deasserts REQ during ADD → DONE still pulses once with the correct sum, and the FSM returns to IDLE.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin shared 5-bit adder (optional OVF via ADDER_CARRY_FLAG_EN)

module adder5_ripple (
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       ci,
    output logic [4:0] s,
    output logic       co
);
    logic [5:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 5; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[5];
    end
endmodule

module adder_share_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 3
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [NREQ-1:0]     REQ,
    input  logic [5*NREQ-1:0]   OPA,
    input  logic [5*NREQ-1:0]   OPB,
    output logic [NREQ-1:0]     GNT,
    output logic                DONE,
    output logic [4:0]          RESULT,
    output logic                BUSY
`ifdef ADDER_CARRY_FLAG_EN
    ,
    output logic                OVF
`endif
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [4:0]        opa_q, opa_d;
    logic [4:0]        opb_q, opb_d;
    logic [4:0]        result_q, result_d;
    logic              win_found;
    logic [4:0]        adder_sum;
    logic              adder_co;

    adder5_ripple u_adder (
        .a  (opa_q),
        .b  (opb_q),
        .ci (1'b0),
        .s  (adder_sum),
        .co (adder_co)
    );

`ifdef ADDER_CARRY_FLAG_EN
    logic ovf_q, ovf_d;
    assign OVF = ovf_q;
`else
    logic adder_co_unused;
    assign adder_co_unused = adder_co;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        win_found = 1'b0;
`ifdef ADDER_CARRY_FLAG_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                // Distance k from the pointer sets priority; wrap is ptr+k-NREQ.
                for (int k = 1; k <= NREQ; k++) begin
                    for (int j = 0; j < NREQ; j++) begin
                        if (!win_found && REQ[j] &&
                            ((int'(ptr_q) + k == j) || (int'(ptr_q) + k == j + NREQ))) begin
                            win_found = 1'b1;
                            gnt_d[j]  = 1'b1;
                            ptr_d     = PTR_W'(j);
                            opa_d     = OPA[5*j +: 5];
                            opb_d     = OPB[5*j +: 5];
                        end
                    end
                end
                if (win_found) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                result_d = adder_sum;
`ifdef ADDER_CARRY_FLAG_EN
                ovf_d    = adder_co;
`endif
                state_d  = S_RESP;
            end
            S_RESP: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            ptr_q    <= PTR_W'(NREQ - 1);
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
`ifdef ADDER_CARRY_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
`ifdef ADDER_CARRY_FLAG_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign GNT    = gnt_q;
    assign DONE   = (state_q == S_RESP);
    assign BUSY   = (state_q != S_IDLE);
    assign RESULT = result_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - directed vector bench for adder_share_arbiter

module tb_adder_share_arbiter;
    logic        CLK;
    logic        RESET_N;
    logic [2:0]  REQ;
    logic [14:0] OPA;
    logic [14:0] OPB;
    logic [2:0]  GNT;
    logic        DONE;
    logic [4:0]  RESULT;
    logic        BUSY;
`ifdef ADDER_CARRY_FLAG_EN
    logic        OVF;
`endif

    int checks = 0;
    int errors = 0;

    adder_share_arbiter #(.NREQ(3), .PTR_W(3)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .REQ     (REQ),
        .OPA     (OPA),
        .OPB     (OPB),
        .GNT     (GNT),
        .DONE    (DONE),
        .RESULT  (RESULT),
        .BUSY    (BUSY)
`ifdef ADDER_CARRY_FLAG_EN
        ,
        .OVF     (OVF)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  req;
        logic [14:0] opa;
        logic [14:0] opb;
        logic [2:0]  exp_gnt;
        logic [4:0]  exp_res;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        REQ     = '0;
        step();
        step();
        RESET_N = 1'b1;
    endtask

    // Called at a negedge with the DUT in IDLE; leaves it at a negedge in IDLE.
    task automatic run_txn(input string tag, input logic [2:0] req, input logic [14:0] opa,
                           input logic [14:0] opb, input logic [2:0] exp_gnt,
                           input logic [4:0] exp_res, input logic exp_ovf);
        REQ = req;
        OPA = opa;
        OPB = opb;
        step();
        chk({tag, "_gnt"}, 32'(GNT), 32'(exp_gnt));
        chk({tag, "_busy_add"}, 32'(BUSY), 32'd1);
        chk({tag, "_done_add"}, 32'(DONE), 32'd0);
        step();
        chk({tag, "_done"}, 32'(DONE), 32'd1);
        chk({tag, "_result"}, 32'(RESULT), 32'(exp_res));
        chk({tag, "_gnt_resp"}, 32'(GNT), 32'(exp_gnt));
`ifdef ADDER_CARRY_FLAG_EN
        chk({tag, "_ovf"}, 32'(OVF), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: unknown ovf expectation in %s", tag);
`endif
        REQ = '0;
        step();
        chk({tag, "_done_idle"}, 32'(DONE), 32'd0);
        chk({tag, "_gnt_idle"}, 32'(GNT), 32'd0);
        chk({tag, "_busy_idle"}, 32'(BUSY), 32'd0);
        chk({tag, "_result_hold"}, 32'(RESULT), 32'(exp_res));
    endtask

    initial begin
        int done_cnt;
        int exp_idx;

        //        req     opa {2,1,0}                opb {2,1,0}                gnt     res    ovf
        vecs[0] = '{3'b001, {5'd0,  5'd0,  5'd7},  {5'd0,  5'd0,  5'd9},  3'b001, 5'd16, 1'b0};
        vecs[1] = '{3'b010, {5'd0,  5'd31, 5'd0},  {5'd0,  5'd1,  5'd0},  3'b010, 5'd0,  1'b1};
        vecs[2] = '{3'b010, {5'd0,  5'd20, 5'd0},  {5'd0,  5'd15, 5'd0},  3'b010, 5'd3,  1'b1};
        vecs[3] = '{3'b010, {5'd0,  5'd10, 5'd0},  {5'd0,  5'd5,  5'd0},  3'b010, 5'd15, 1'b0};
        vecs[4] = '{3'b110, {5'd17, 5'd3,  5'd0},  {5'd14, 5'd3,  5'd0},  3'b100, 5'd31, 1'b0};
        vecs[5] = '{3'b011, {5'd0,  5'd4,  5'd16}, {5'd0,  5'd4,  5'd16}, 3'b001, 5'd0,  1'b1};
        vecs[6] = '{3'b101, {5'd9,  5'd0,  5'd1},  {5'd30, 5'd0,  5'd1},  3'b100, 5'd7,  1'b1};
        vecs[7] = '{3'b111, {5'd1,  5'd2,  5'd0},  {5'd1,  5'd2,  5'd0},  3'b001, 5'd0,  1'b0};

        OPA = '0;
        OPB = '0;
        do_reset();
        chk("reset_gnt", 32'(GNT), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_result", 32'(RESULT), 32'd0);
`ifdef ADDER_CARRY_FLAG_EN
        chk("reset_ovf", 32'(OVF), 32'd0);
`endif

        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].opa, vecs[i].opb,
                    vecs[i].exp_gnt, vecs[i].exp_res, vecs[i].exp_ovf);
        end

        // Round robin with all requests held high from a fresh reset.
        do_reset();
        REQ = 3'b111;
        OPA = {5'd3, 5'd2, 5'd1};
        OPB = {5'd3, 5'd2, 5'd1};
        done_cnt = 0;
        for (int t = 0; t < 6; t++) begin
            exp_idx = t % 3;
            step();
            chk($sformatf("rr%0d_gnt", t), 32'(GNT), 32'(1 << exp_idx));
            if (DONE) done_cnt++;
            step();
            chk($sformatf("rr%0d_done", t), 32'(DONE), 32'd1);
            chk($sformatf("rr%0d_result", t), 32'(RESULT), 32'(2 * (exp_idx + 1)));
            if (DONE) done_cnt++;
            step();
            chk($sformatf("rr%0d_idle_gnt", t), 32'(GNT), 32'd0);
            if (DONE) done_cnt++;
        end
        chk("rr_done_count", 32'(done_cnt), 32'd6);
        REQ = '0;
        step();

        // Operand change during ADD must not affect the latched sum.
        do_reset();
        REQ = 3'b001;
        OPA = {5'd0, 5'd0, 5'd4};
        OPB = {5'd0, 5'd0, 5'd4};
        step();
        chk("hold_gnt", 32'(GNT), 32'd1);
        OPA = {5'd0, 5'd0, 5'd30};
        step();
        chk("hold_done", 32'(DONE), 32'd1);
        chk("hold_result", 32'(RESULT), 32'd8);
        REQ = '0;
        step();

        // Reset during ADD aborts the transaction and restores req0-first priority.
        REQ = 3'b010;
        OPA = {5'd0, 5'd5, 5'd0};
        OPB = {5'd0, 5'd5, 5'd0};
        step();
        chk("midrst_gnt_add", 32'(GNT), 32'd2);
        RESET_N = 1'b0;
        REQ = '0;
        step();
        RESET_N = 1'b1;
        chk("midrst_gnt", 32'(GNT), 32'd0);
        chk("midrst_done", 32'(DONE), 32'd0);
        chk("midrst_result", 32'(RESULT), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        done_cnt = 0;
        for (int t = 0; t < 3; t++) begin
            step();
            if (DONE) done_cnt++;
        end
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        run_txn("midrst_req110", 3'b110, {5'd0, 5'd6, 5'd0}, {5'd0, 5'd7, 5'd0}, 3'b010, 5'd13, 1'b0);
        run_txn("midrst_req100", 3'b100, {5'd8, 5'd0, 5'd0}, {5'd8, 5'd0, 5'd0}, 3'b100, 5'd16, 1'b0);

        // Requester drops REQ during ADD; transaction still completes once.
        REQ = 3'b001;
        OPA = {5'd0, 5'd0, 5'd12};
        OPB = {5'd0, 5'd0, 5'd13};
        step();
        chk("drop_gnt", 32'(GNT), 32'd1);
        REQ = '0;
        step();
        chk("drop_done", 32'(DONE), 32'd1);
        chk("drop_result", 32'(RESULT), 32'd25);
        step();
        chk("drop_idle_done", 32'(DONE), 32'd0);
        chk("drop_idle_busy", 32'(BUSY), 32'd0);
        step();
        chk("drop_no_second_done", 32'(DONE), 32'd0);
        chk("drop_stay_idle", 32'(BUSY), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
